// File: rtl/qsort_pkg.sv
// Shared types for the quicksort sequencer: index width, subrange entry, FSM states.
package qsort_pkg;

    localparam int QS_K  = 10;
    localparam int QS_IW = $clog2(QS_K) + 1;

    typedef struct packed {
        logic [QS_IW-1:0] base;
        logic [QS_IW-1:0] count;
    } range_t;

    // state      | meaning
    // S_IDLE     | waiting for start
    // S_WAIT_MEM | waiting for the array load to finish
    // S_POP      | take the next subrange off the stack, or finish
    // S_SETUP    | part_start low with stable base/count so the engine reloads
    // S_RUN      | partition in progress
    // S_CAPTURE  | compute left/right sizes around the pivot
    // S_PUSH_R   | push the right subrange
    // S_PUSH_L   | push the left subrange (processed first)
    // S_FINISH   | pulse done
    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_MEM, S_POP, S_SETUP, S_RUN,
        S_CAPTURE, S_PUSH_R, S_PUSH_L, S_FINISH
    } state_t;

endpackage

// File: rtl/qsort_stack.sv
// Synchronous LIFO of pending subranges; top is the most recent push.
module qsort_stack
    import qsort_pkg::*;
#(
    parameter int SD = QS_K
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  range_t din,
    output range_t top,
    output logic   empty,
    output logic   full
);
    localparam int PW = $clog2(SD + 1);
    localparam int AW = (SD > 1) ? $clog2(SD) : 1;

    range_t        mem [SD];
    logic [PW-1:0] sp;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign empty  = (sp == '0);
    assign full   = (sp == PW'(SD));
    assign wr_idx = AW'(sp);
    assign rd_idx = AW'(sp - 1'b1);
    assign top    = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_idx] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                sp <= '0;
        else if (push && !full)    sp <= sp + 1'b1;
        else if (pop && !empty)    sp <= sp - 1'b1;
    end

endmodule

// File: rtl/qsort_sched.sv
// Quicksort sequencer: keeps a LIFO of pending subranges and launches one engine
// partition at a time until no subrange of two or more elements remains.
module qsort_sched
    import qsort_pkg::*;
#(
    parameter  int SD = QS_K,
    localparam int IW = QS_IW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [IW-1:0] n_elem,
    input  logic          mem_loaded,
    output logic          part_start,
    output logic [IW-1:0] part_base,
    output logic [IW-1:0] part_count,
    input  logic          part_done,
    input  logic [IW-1:0] part_index,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [IW+3:0] n_parts
);
    state_t        state;
    logic [IW-1:0] n_lat;
    logic [IW-1:0] p;
    logic [IW-1:0] lc;
    logic [IW-1:0] rc;
    logic [IW-1:0] last;
    logic          keep;
    logic          in_range;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    range_t        push_data;
    range_t        top;

    qsort_stack #(.SD(SD)) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .top   (top),
        .empty (empty),
        .full  (full)
    );

    assign last     = part_base + part_count - IW'(1);
    assign in_range = (p >= part_base) && (p <= last);

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        unique case (state)
            S_WAIT_MEM: if (mem_loaded && n_lat >= IW'(2)) begin
                push            = 1'b1;
                push_data.count = n_lat;
            end
            S_POP:      pop = !empty;
            S_PUSH_R:   if (keep && rc >= IW'(2)) begin
                push            = 1'b1;
                push_data.base  = p + 1'b1;
                push_data.count = rc;
            end
            S_PUSH_L:   if (keep && lc >= IW'(2)) begin
                push            = 1'b1;
                push_data.base  = part_base;
                push_data.count = lc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            part_start <= 1'b0;
            part_base  <= '0;
            part_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            n_parts    <= '0;
            n_lat      <= '0;
            p          <= '0;
            lc         <= '0;
            rc         <= '0;
            keep       <= 1'b0;
        end else begin
            done <= 1'b0;
            // A push into a full stack drops the entry; the flag stays until next start.
            if (push && full) overflow <= 1'b1;
            unique case (state)
                S_IDLE: if (start) begin
                    n_lat    <= n_elem;
                    busy     <= 1'b1;
                    overflow <= 1'b0;
                    n_parts  <= '0;
                    state    <= S_WAIT_MEM;
                end
                S_WAIT_MEM: if (mem_loaded) begin
                    state <= (n_lat < IW'(2)) ? S_FINISH : S_POP;
                end
                S_POP: begin
                    if (empty) begin
                        state <= S_FINISH;
                    end else begin
                        part_base  <= top.base;
                        part_count <= top.count;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    part_start <= 1'b1;
                    n_parts    <= n_parts + 1'b1;
                    state      <= S_RUN;
                end
                S_RUN: if (part_done) begin
                    p          <= part_index;
                    part_start <= 1'b0;
                    state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    lc    <= p - part_base;
                    rc    <= last - p;
                    keep  <= in_range;
                    if (!in_range) overflow <= 1'b1;
                    state <= S_PUSH_R;
                end
                S_PUSH_R: state <= S_PUSH_L;
                S_PUSH_L: state <= S_POP;
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
